// File: rtl/flash_spi_arb_if.sv
// Shared SPI flash bus: engine request/grant handshake, per-engine SPI lines and the flash pins.
// slave = arbiter side, master = engine/flash side.
interface flash_spi_arb_if;
  logic req_wr;
  logic req_rd;
  logic gnt_wr;
  logic gnt_rd;
  logic cs_n_wr;
  logic sck_wr;
  logic mosi_wr;
  logic cs_n_rd;
  logic sck_rd;
  logic mosi_rd;
  logic cs_n;
  logic sck;
  logic mosi;
  logic flash_rd_busy;
  logic timeout_err;

  modport slave (
    input  req_wr, req_rd,
    input  cs_n_wr, sck_wr, mosi_wr,
    input  cs_n_rd, sck_rd, mosi_rd,
    output gnt_wr, gnt_rd,
    output cs_n, sck, mosi,
    output flash_rd_busy, timeout_err
  );

  modport master (
    output req_wr, req_rd,
    output cs_n_wr, sck_wr, mosi_wr,
    output cs_n_rd, sck_rd, mosi_rd,
    input  gnt_wr, gnt_rd,
    input  cs_n, sck, mosi,
    input  flash_rd_busy, timeout_err
  );
endinterface

// File: rtl/flash_spi_arb.sv
// Round-robin owner arbiter for the single SPI flash bus (write engine vs read engine) with a cs_n-high guard.
// Optional ownership watchdog: define FLASH_ARB_TIMEOUT_EN.
module flash_spi_arb #(
  parameter int unsigned GUARD_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic           clk,
  input  logic           rst_n,
  flash_spi_arb_if.slave bus
);

  localparam int unsigned GUARD_W  = 8;
  localparam logic        OWNER_WR = 1'b0;
  localparam logic        OWNER_RD = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_WR = 2'd1,
    OWN_RD = 2'd2,
    GUARD  = 2'd3
  } state_t;

  if (GUARD_CYCLES < 1 || GUARD_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("flash_spi_arb: GUARD_CYCLES must be 1..255 and TIMEOUT_CYCLES at least 1");
  end

  state_t               state;
  state_t               state_d;
  logic [GUARD_W-1:0]   guard_cnt;
  logic [GUARD_W-1:0]   guard_cnt_d;
  logic                 last_owner;
  logic                 last_owner_d;
  logic                 rel_wr;
  logic                 rel_rd;
  logic                 tmo_hit;
  logic                 pin_cs_n;
  logic                 pin_sck;
  logic                 pin_mosi;

  // Voluntary release: request gone and the owner has already raised cs_n.
  assign rel_wr = !bus.req_wr && bus.cs_n_wr;
  assign rel_rd = !bus.req_rd && bus.cs_n_rd;

`ifdef FLASH_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_cnt_d;
  logic             timeout_err_q;

  // Counts owned cycles; zero in every non-owner state so each ownership starts fresh.
  always_comb begin
    tmo_cnt_d = '0;
    if (state == OWN_WR || state == OWN_RD) begin
      tmo_cnt_d = tmo_cnt + TMO_W'(1);
    end
  end

  assign tmo_hit = (state == OWN_WR || state == OWN_RD) &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt       <= tmo_cnt_d;
      timeout_err_q <= tmo_hit;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  assign tmo_hit         = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // State register plus the arbitration/guard bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      guard_cnt  <= '0;
      last_owner <= OWNER_WR;
    end else begin
      state      <= state_d;
      guard_cnt  <= guard_cnt_d;
      last_owner <= last_owner_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state;
    guard_cnt_d  = guard_cnt;
    last_owner_d = last_owner;
    case (state)
      IDLE: begin
        if (bus.req_wr && bus.req_rd) begin
          state_d = (last_owner == OWNER_WR) ? OWN_RD : OWN_WR;
        end else if (bus.req_wr) begin
          state_d = OWN_WR;
        end else if (bus.req_rd) begin
          state_d = OWN_RD;
        end
      end
      OWN_WR: begin
        if (tmo_hit || rel_wr) begin
          state_d      = GUARD;
          guard_cnt_d  = GUARD_W'(GUARD_CYCLES - 1);
          last_owner_d = OWNER_WR;
        end
      end
      OWN_RD: begin
        if (tmo_hit || rel_rd) begin
          state_d      = GUARD;
          guard_cnt_d  = GUARD_W'(GUARD_CYCLES - 1);
          last_owner_d = OWNER_RD;
        end
      end
      GUARD: begin
        if (guard_cnt == '0) begin
          state_d = IDLE;
        end else begin
          guard_cnt_d = guard_cnt - GUARD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin mux from the registered owner; non-owners see SPI mode 0 idle.
  always_comb begin
    pin_cs_n = 1'b1;
    pin_sck  = 1'b0;
    pin_mosi = 1'b0;
    case (state)
      OWN_WR: begin
        pin_cs_n = bus.cs_n_wr;
        pin_sck  = bus.sck_wr;
        pin_mosi = bus.mosi_wr;
      end
      OWN_RD: begin
        pin_cs_n = bus.cs_n_rd;
        pin_sck  = bus.sck_rd;
        pin_mosi = bus.mosi_rd;
      end
      default: ;
    endcase
  end

  assign bus.cs_n          = pin_cs_n;
  assign bus.sck           = pin_sck;
  assign bus.mosi          = pin_mosi;
  assign bus.gnt_wr        = (state == OWN_WR);
  assign bus.gnt_rd        = (state == OWN_RD);
  assign bus.flash_rd_busy = (state == OWN_RD);

endmodule

// File: tb/tb_flash_spi_arb.sv
// Bench for flash_spi_arb (GUARD_CYCLES=4, TIMEOUT_CYCLES=16): vector table through an expectation queue,
// plus reset, cs_n-hold and watchdog sequences.
module tb_flash_spi_arb;

  localparam int unsigned GUARD = 4;
  localparam int unsigned TMO   = 16;
  localparam int unsigned NV    = 18;

  // Output word: {gnt_wr, gnt_rd, flash_rd_busy, cs_n, sck, mosi, timeout_err}
  localparam logic [6:0] E_IDLE = 7'b000_100_0;

  typedef struct {
    logic       req_wr;
    logic       req_rd;
    logic [2:0] spi_wr;  // {cs_n, sck, mosi}
    logic [2:0] spi_rd;
    logic [6:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  vec_t       tbl [NV];
  logic [6:0] exp_q [$];
  int         id_q [$];

  flash_spi_arb_if bus ();

  flash_spi_arb #(
    .GUARD_CYCLES   (GUARD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [6:0] e_wr(input logic [2:0] pins);
    return {3'b100, pins, 1'b0};
  endfunction

  function automatic logic [6:0] e_rd(input logic [2:0] pins);
    return {3'b011, pins, 1'b0};
  endfunction

  function automatic vec_t mk(input logic rw, input logic rr, input logic [2:0] sw,
                              input logic [2:0] sr, input logic [6:0] e);
    vec_t v;
    v.req_wr = rw;
    v.req_rd = rr;
    v.spi_wr = sw;
    v.spi_rd = sr;
    v.exp    = e;
    return v;
  endfunction

  function automatic logic [6:0] outs();
    return {bus.gnt_wr, bus.gnt_rd, bus.flash_rd_busy, bus.cs_n, bus.sck, bus.mosi, bus.timeout_err};
  endfunction

  task automatic drive(input logic rw, input logic rr, input logic [2:0] sw, input logic [2:0] sr);
    bus.req_wr = rw;
    bus.req_rd = rr;
    {bus.cs_n_wr, bus.sck_wr, bus.mosi_wr} = sw;
    {bus.cs_n_rd, bus.sck_rd, bus.mosi_rd} = sr;
  endtask

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b required %b (gnt_wr gnt_rd busy cs_n sck mosi tmo)", name, act, exp);
    end
  endtask

  // Let one active edge pass, then sample on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 3'b100, 3'b100);
    rst_n = 1'b0;
    #1;
    check("reset", outs(), E_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;

    // Tie after reset (rd wins), held cs_n low, guard with wr toggling, wr grant, tie again (rd wins).
    tbl[0]  = mk(1'b0, 1'b0, 3'b100, 3'b100, E_IDLE);
    tbl[1]  = mk(1'b1, 1'b1, 3'b010, 3'b011, e_rd(3'b011));
    tbl[2]  = mk(1'b1, 1'b1, 3'b001, 3'b001, e_rd(3'b001));
    tbl[3]  = mk(1'b1, 1'b0, 3'b010, 3'b000, e_rd(3'b000));
    tbl[4]  = mk(1'b1, 1'b0, 3'b011, 3'b100, E_IDLE);
    tbl[5]  = mk(1'b1, 1'b0, 3'b010, 3'b100, E_IDLE);
    tbl[6]  = mk(1'b1, 1'b0, 3'b001, 3'b111, E_IDLE);
    tbl[7]  = mk(1'b1, 1'b0, 3'b011, 3'b100, E_IDLE);
    tbl[8]  = mk(1'b1, 1'b0, 3'b000, 3'b100, E_IDLE);
    tbl[9]  = mk(1'b1, 1'b0, 3'b010, 3'b100, e_wr(3'b010));
    tbl[10] = mk(1'b1, 1'b1, 3'b001, 3'b011, e_wr(3'b001));
    tbl[11] = mk(1'b0, 1'b1, 3'b100, 3'b011, E_IDLE);
    tbl[12] = mk(1'b1, 1'b1, 3'b000, 3'b010, E_IDLE);
    tbl[13] = mk(1'b1, 1'b1, 3'b010, 3'b010, E_IDLE);
    tbl[14] = mk(1'b1, 1'b1, 3'b000, 3'b010, E_IDLE);
    tbl[15] = mk(1'b1, 1'b1, 3'b010, 3'b010, E_IDLE);
    tbl[16] = mk(1'b1, 1'b1, 3'b011, 3'b010, e_rd(3'b010));
    tbl[17] = mk(1'b1, 1'b0, 3'b011, 3'b100, E_IDLE);

    @(negedge clk);
    do_reset();

    for (int i = 0; i < int'(NV); i++) begin
      drive(tbl[i].req_wr, tbl[i].req_rd, tbl[i].spi_wr, tbl[i].spi_rd);
      exp_q.push_back(tbl[i].exp);
      id_q.push_back(i);
      tick();
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard: got empty queue required pending entry");
      end else begin
        check($sformatf("vec%0d", id_q.pop_front()), outs(), exp_q.pop_front());
      end
    end

    // Single read request, then asynchronous reset in the middle of the ownership.
    do_reset();
    drive(1'b0, 1'b1, 3'b100, 3'b011);
    tick();
    check("rd_alone", outs(), e_rd(3'b011));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", outs(), E_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rd_regrant", outs(), e_rd(3'b011));

    // Owner drops its request but keeps cs_n low for 10 cycles.
    do_reset();
    drive(1'b1, 1'b0, 3'b000, 3'b100);
    tick();
    check("hold_grant", outs(), e_wr(3'b000));
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, (i % 2 == 0) ? 3'b010 : 3'b001, 3'b100);
      tick();
      check($sformatf("hold_low%0d", i), outs(), e_wr((i % 2 == 0) ? 3'b010 : 3'b001));
    end
    drive(1'b0, 1'b0, 3'b100, 3'b100);
    tick();
    check("hold_release", outs(), E_IDLE);

`ifdef FLASH_ARB_TIMEOUT_EN
    // Write engine never lets go; watchdog revokes after TMO owned cycles.
    do_reset();
    drive(1'b1, 1'b0, 3'b000, 3'b100);
    tick();
    check("tmo_own1", outs(), e_wr(3'b000));
    drive(1'b1, 1'b1, 3'b000, 3'b011);
    for (int i = 2; i <= int'(TMO); i++) begin
      tick();
      check($sformatf("tmo_own%0d", i), outs(), e_wr(3'b000));
    end
    tick();
    check("tmo_revoke", outs(), 7'b000_100_1);
    for (int i = 0; i < int'(GUARD); i++) begin
      tick();
      check($sformatf("tmo_guard%0d", i), outs(), E_IDLE);
    end
    tick();
    check("tmo_rd_grant", outs(), e_rd(3'b011));
`else
    // Without the watchdog a stuck owner keeps the bus.
    do_reset();
    drive(1'b1, 1'b0, 3'b000, 3'b100);
    tick();
    check("stuck_own1", outs(), e_wr(3'b000));
    drive(1'b1, 1'b1, 3'b000, 3'b011);
    for (int i = 2; i <= int'(TMO) + 4; i++) begin
      tick();
      check($sformatf("stuck_own%0d", i), outs(), e_wr(3'b000));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
